keyed_alu_pipe: RTL and testbench

- Parametrised, two-stage pipelined, key-gated ALU with valid/ready handshakes on input and output.
- Operands and select are registered in stage 1. The result and overflow flag are registered in stage 2.
- A key-unlock FSM gates results. While the block is not unlocked, every result is forced to zero.
- Sits between an operand producer and a result consumer in the datapath under security-dependency analysis.

---
 rtl/keyed_alu_pkg.sv | 17 +
 rtl/keyed_alu_lock.sv | 76 +++++++
 rtl/keyed_alu_pipe.sv | 128 ++++++++++++
 tb/tb_keyed_alu_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keyed_alu_pkg.sv
// Shared types for the key-gated pipelined ALU: op select encoding and lock FSM states.
package keyed_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ADDC = 2'b10,
    OP_SUBC = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    LOCKED   = 2'b00,
    UNLOCKED = 2'b01,
    BLOCKED  = 2'b10
  } lock_state_e;

endpackage

// File: rtl/keyed_alu_lock.sv
// Key-unlock FSM with wrong-attempt counter; BLOCKED is sticky until reset.
module keyed_alu_lock
  import keyed_alu_pkg::*;
#(
  parameter int               KEY_W     = 8,
  parameter logic [KEY_W-1:0] KEY_VALUE = 8'h5A,
  parameter int               MAX_FAIL  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key,
  input  logic             key_load,
  output logic             unlocked,
  output logic             locked,
  output logic             blocked
);

  localparam int FAIL_W = (MAX_FAIL < 2) ? 1 : $clog2(MAX_FAIL + 1);

  lock_state_e       state_q;
  logic [FAIL_W-1:0] fail_q;
  logic              unlocked_q;
  logic              locked_q;
  logic              blocked_q;
  logic              match;

  assign match = (key == KEY_VALUE);

  // Status flags are registered alongside the state so they always mirror state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOCKED;
      fail_q     <= '0;
      unlocked_q <= 1'b0;
      locked_q   <= 1'b1;
      blocked_q  <= 1'b0;
    end else if (key_load) begin
      unique case (state_q)
        LOCKED: begin
          if (match) begin
            state_q    <= UNLOCKED;
            fail_q     <= '0;
            unlocked_q <= 1'b1;
            locked_q   <= 1'b0;
          end else begin
            fail_q <= fail_q + FAIL_W'(1);
            if (int'(fail_q) + 1 >= MAX_FAIL) begin
              state_q   <= BLOCKED;
              blocked_q <= 1'b1;
            end
          end
        end
        UNLOCKED: begin
          if (!match) begin
            fail_q     <= FAIL_W'(1);
            unlocked_q <= 1'b0;
            locked_q   <= 1'b1;
            if (MAX_FAIL == 1) begin
              state_q   <= BLOCKED;
              blocked_q <= 1'b1;
            end else begin
              state_q <= LOCKED;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign unlocked = unlocked_q;
  assign locked   = locked_q;
  assign blocked  = blocked_q;

endmodule

// File: rtl/keyed_alu_pipe.sv
// Two-stage key-gated ALU pipeline with valid/ready on both sides and a completed-op counter.
// Build option KEYED_ALU_SAT_EN selects unsigned saturating arithmetic instead of wrapping.
module keyed_alu_pipe
  import keyed_alu_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               KEY_W     = 8,
  parameter logic [KEY_W-1:0] KEY_VALUE = 8'h5A,
  parameter logic [WIDTH-1:0] CONST     = 8'hAA,
  parameter int               MAX_FAIL  = 3,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [KEY_W-1:0] key,
  input  logic             key_load,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             ovf,
  output logic             locked,
  output logic             blocked,
  output logic [CNT_W-1:0] op_count
);

  logic             unlocked;
  logic             v1_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  alu_op_e          op_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;

  logic             adv2;
  logic             accept;
  logic             load2;
  logic [WIDTH-1:0] op2;
  logic             is_sub;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res_d;
  logic             ovf_d;

  keyed_alu_lock #(
    .KEY_W    (KEY_W),
    .KEY_VALUE(KEY_VALUE),
    .MAX_FAIL (MAX_FAIL)
  ) u_lock (
    .clk     (clk),
    .rst     (rst),
    .key     (key),
    .key_load(key_load),
    .unlocked(unlocked),
    .locked  (locked),
    .blocked (blocked)
  );

  // A beat transfers on a side when valid & ready are both high at a clock edge; a
  // producer holds valid and data stable until it transfers, and ready never looks at valid.
  assign adv2     = !out_valid_q || out_ready;
  assign in_ready = !v1_q || adv2;
  assign accept   = in_valid && in_ready;
  assign load2    = adv2 && v1_q;

  always_comb begin
    op2    = (op_q == OP_ADDC || op_q == OP_SUBC) ? CONST : b_q;
    is_sub = (op_q == OP_SUB || op_q == OP_SUBC);
    sum    = {1'b0, a_q} + {1'b0, op2};
    diff   = {1'b0, a_q} - {1'b0, op2};
    ovf_d  = is_sub ? diff[WIDTH] : sum[WIDTH];
    res_d  = is_sub ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
`ifdef KEYED_ALU_SAT_EN
    if (ovf_d) begin
      res_d = is_sub ? '0 : '1;
    end
`endif
    // Lock state is taken from the registered FSM, so a same-cycle key_load has no effect here.
    if (!unlocked) begin
      res_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (accept) begin
        v1_q <= 1'b1;
        a_q  <= in1;
        b_q  <= in2;
        op_q <= alu_op_e'(sel);
      end else if (load2) begin
        v1_q <= 1'b0;
      end
      if (adv2) begin
        out_valid_q <= v1_q;
      end
      if (load2) begin
        out_q <= res_d;
        ovf_q <= ovf_d;
      end
      if (out_valid_q && out_ready) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign ovf       = ovf_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_keyed_alu_pipe.sv
// Directed self-checking bench for keyed_alu_pipe (default parameters; honours KEYED_ALU_SAT_EN).
module tb_keyed_alu_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sel;
  logic [7:0]  in1;
  logic [7:0]  in2;
  logic [7:0]  key;
  logic        key_load;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out;
  logic        ovf;
  logic        locked;
  logic        blocked;
  logic [15:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

`ifdef KEYED_ALU_SAT_EN
  localparam logic [7:0] E_SUB  = 8'h00;
  localparam logic [7:0] E_ADDC = 8'hFF;
  localparam logic [7:0] E_WRAP = 8'hFF;
`else
  localparam logic [7:0] E_SUB  = 8'hFE;
  localparam logic [7:0] E_ADDC = 8'h0A;
  localparam logic [7:0] E_WRAP = 8'h00;
`endif

  keyed_alu_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .in1      (in1),
    .in2      (in2),
    .key      (key),
    .key_load (key_load),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .ovf      (ovf),
    .locked   (locked),
    .blocked  (blocked),
    .op_count (op_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; key_load = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic load_key(input logic [7:0] k);
    key = k; key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  // Drives one beat into an idle pipe and samples the result cycle and the count after it.
  task automatic do_op(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b,
                       output logic early_v, output logic v, output logic [7:0] o,
                       output logic f, output logic [15:0] cnt);
    sel = s; in1 = a; in2 = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    early_v = out_valid;
    tick();
    v = out_valid; o = out; f = ovf;
    tick();
    cnt = op_count;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (out !== 8'h00) begin n_fail++; $display("FAIL rst_out: got %h expected 00", out); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    n_tests++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL rst_op_count: got %0d expected 0", op_count); end
    n_tests++; if ({locked, blocked} !== 2'b10) begin n_fail++; $display("FAIL rst_lock: got %b expected 10", {locked, blocked}); end
  endtask

  task automatic test_unlock_add();
    logic e, v, f; logic [7:0] o; logic [15:0] c;
    do_reset();
    load_key(8'h5A);
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL t1_locked: got %b expected 0", locked); end
    do_op(2'b00, 8'h10, 8'h22, e, v, o, f, c);
    n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL t1_early_valid: got %b expected 0", e); end
    n_tests++; if (v !== 1'b1) begin n_fail++; $display("FAIL t1_valid: got %b expected 1", v); end
    n_tests++; if (o !== 8'h32) begin n_fail++; $display("FAIL t1_out: got %h expected 32", o); end
    n_tests++; if (f !== 1'b0) begin n_fail++; $display("FAIL t1_ovf: got %b expected 0", f); end
    n_tests++; if (c !== 16'd1) begin n_fail++; $display("FAIL t1_count: got %0d expected 1", c); end
  endtask

  task automatic test_arith();
    logic e, v, f; logic [7:0] o; logic [15:0] c;
    do_op(2'b01, 8'h05, 8'h07, e, v, o, f, c);
    n_tests++; if ({o, f} !== {E_SUB, 1'b1}) begin n_fail++; $display("FAIL t2_sub: got %h/%b expected %h/1", o, f, E_SUB); end
    do_op(2'b10, 8'h60, 8'h00, e, v, o, f, c);
    n_tests++; if ({o, f} !== {E_ADDC, 1'b1}) begin n_fail++; $display("FAIL t2_addc: got %h/%b expected %h/1", o, f, E_ADDC); end
    do_op(2'b11, 8'hAB, 8'h00, e, v, o, f, c);
    n_tests++; if ({o, f} !== {8'h01, 1'b0}) begin n_fail++; $display("FAIL t2_subc: got %h/%b expected 01/0", o, f); end
    do_op(2'b00, 8'hFF, 8'h01, e, v, o, f, c);
    n_tests++; if ({o, f} !== {E_WRAP, 1'b1}) begin n_fail++; $display("FAIL t2_add_carry: got %h/%b expected %h/1", o, f, E_WRAP); end
    do_op(2'b01, 8'h07, 8'h07, e, v, o, f, c);
    n_tests++; if ({o, f} !== {8'h00, 1'b0}) begin n_fail++; $display("FAIL t2_sub_equal: got %h/%b expected 00/0", o, f); end
  endtask

  task automatic test_locked_gating();
    logic e, v, f; logic [7:0] o; logic [15:0] c;
    do_reset();
    do_op(2'b10, 8'h01, 8'h00, e, v, o, f, c);
    n_tests++; if ({v, o, f} !== {1'b1, 8'h00, 1'b0}) begin n_fail++; $display("FAIL t3_gated: got v%b %h/%b expected v1 00/0", v, o, f); end
    n_tests++; if (c !== 16'd1) begin n_fail++; $display("FAIL t3_count: got %0d expected 1", c); end
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL t3_locked: got %b expected 1", locked); end
  endtask

  task automatic test_block();
    logic e, v, f; logic [7:0] o; logic [15:0] c;
    do_reset();
    load_key(8'h00);
    load_key(8'h00);
    n_tests++; if (blocked !== 1'b0) begin n_fail++; $display("FAIL t4_blocked_2: got %b expected 0", blocked); end
    load_key(8'h00);
    n_tests++; if (blocked !== 1'b1) begin n_fail++; $display("FAIL t4_blocked_3: got %b expected 1", blocked); end
    load_key(8'h5A);
    n_tests++; if ({locked, blocked} !== 2'b11) begin n_fail++; $display("FAIL t4_sticky: got %b expected 11", {locked, blocked}); end
    do_op(2'b00, 8'h01, 8'h01, e, v, o, f, c);
    n_tests++; if ({v, o} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL t4_out: got v%b %h expected v1 00", v, o); end
    do_reset();
    n_tests++; if ({locked, blocked} !== 2'b10) begin n_fail++; $display("FAIL t4_rst: got %b expected 10", {locked, blocked}); end
  endtask

  task automatic test_relock();
    do_reset();
    load_key(8'h5A);
    load_key(8'h33);
    n_tests++; if ({locked, blocked} !== 2'b10) begin n_fail++; $display("FAIL relock_1: got %b expected 10", {locked, blocked}); end
    load_key(8'h33);
    n_tests++; if (blocked !== 1'b0) begin n_fail++; $display("FAIL relock_2: got %b expected 0", blocked); end
    load_key(8'h33);
    n_tests++; if (blocked !== 1'b1) begin n_fail++; $display("FAIL relock_3: got %b expected 1", blocked); end
  endtask

  task automatic test_back_to_back();
    logic acc;
    int cycles;
    do_reset();
    load_key(8'h5A);
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) exp_q.push_back(8'(i + i));
    sel = 2'b00; in1 = 8'h01; in2 = 8'h01; in_valid = 1'b1;
    tick();
    in1 = 8'h02; in2 = 8'h02;
    tick();
    in1 = 8'h03; in2 = 8'h03;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL t5_in_ready: got %b expected 0", in_ready); end
    tick();
    n_tests++; if ({out_valid, out, in_ready} !== {1'b1, 8'h02, 1'b0}) begin
      n_fail++; $display("FAIL t5_hold: got v%b %h rdy%b expected v1 02 rdy0", out_valid, out, in_ready); end
    out_ready = 1'b1;
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 20) begin
      if (out_valid) begin
        n_tests++; if (out !== exp_q[0]) begin n_fail++; $display("FAIL t5_order: got %h expected %h", out, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
      cycles++;
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL t5_drain: got %0d pending expected 0", exp_q.size()); end
    exp_q.delete();
    in_valid = 1'b0;
    n_tests++; if (op_count !== 16'd3) begin n_fail++; $display("FAIL t5_count: got %0d expected 3", op_count); end
  endtask

  task automatic test_reset_mid();
    logic e, v, f; logic [7:0] o; logic [15:0] c;
    do_reset();
    load_key(8'h5A);
    do_op(2'b00, 8'h04, 8'h04, e, v, o, f, c);
    out_ready = 1'b0;
    sel = 2'b00; in1 = 8'h05; in2 = 8'h05; in_valid = 1'b1;
    tick();
    in1 = 8'h06;
    tick();
    in_valid = 1'b0;
    n_tests++; if ({out_valid, op_count} !== {1'b1, 16'd1}) begin
      n_fail++; $display("FAIL t6_pre: got v%b cnt%0d expected v1 cnt1", out_valid, op_count); end
    rst = 1'b1;
    tick();
    n_tests++; if ({out_valid, in_ready, out} !== {1'b0, 1'b1, 8'h00}) begin
      n_fail++; $display("FAIL t6_pipe: got v%b rdy%b %h expected v0 rdy1 00", out_valid, in_ready, out); end
    n_tests++; if ({op_count, locked} !== {16'd0, 1'b1}) begin
      n_fail++; $display("FAIL t6_state: got cnt%0d lk%b expected cnt0 lk1", op_count, locked); end
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sel = 2'b00; in1 = 8'h00; in2 = 8'h00;
    key = 8'h00; key_load = 1'b0; out_ready = 1'b1;
    test_reset();
    test_unlock_add();
    test_arith();
    test_locked_gating();
    test_block();
    test_relock();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
